// File: rtl/johnson_phase_monitor.sv
// Phase monitor for a 4-bit Johnson counter: decodes phase, checks step legality, tracks lock/revolutions/errors.
// Optional build macro JPM_STALL_EN: when defined, a repeated sample (stall) is treated as legal.
module johnson_phase_monitor #(
    parameter int LOCK_N = 4,
    parameter int REV_W  = 8,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             i,
    input  logic [3:0]       q,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic [7:0]       phase_oh,
    output logic             valid,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_cnt,
    output logic             illegal,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // state  | meaning
    // ACQ    | counting consecutive successor steps toward lock
    // LOCKED | sequence tracked, phase outputs valid
    // ERROR  | one-cycle penalty after a violation, then back to ACQ
    typedef enum logic [1:0] {ACQ, LOCKED, ERROR} state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);

    state_t     state;
    logic [3:0] q_p;
    logic [3:0] good_cnt;
    logic       first_smp;

    logic [3:0] q_dec, p_dec;
    logic       is_illegal, is_stall, is_succ, stall_bad, violation;
    logic [ERR_W-1:0] err_cnt_inc;

    // returns {legal, phase}
    function automatic logic [3:0] decode(input logic [3:0] c);
        case (c)
            4'b0000: decode = 4'b1_000;
            4'b1000: decode = 4'b1_001;
            4'b1100: decode = 4'b1_010;
            4'b1110: decode = 4'b1_011;
            4'b1111: decode = 4'b1_100;
            4'b0111: decode = 4'b1_101;
            4'b0011: decode = 4'b1_110;
            4'b0001: decode = 4'b1_111;
            default: decode = 4'b0_000;
        endcase
    endfunction

    always_comb begin
        q_dec      = decode(q);
        p_dec      = decode(q_p);
        is_illegal = !q_dec[3];
        is_stall   = !is_illegal && (q == q_p);
        is_succ    = !is_illegal && p_dec[3] && (q_dec[2:0] == p_dec[2:0] + 3'd1);
`ifdef JPM_STALL_EN
        stall_bad  = 1'b0;
`else
        // the very first sample after reset compares against the reset value of q_p
        stall_bad  = is_stall && !first_smp;
`endif
        violation  = is_illegal || stall_bad || (!is_stall && !is_succ);
        err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!i) begin
            state     <= ACQ;
            q_p       <= 4'b0000;
            good_cnt  <= 4'd0;
            first_smp <= 1'b1;
            phase     <= 3'd0;
            phase_oh  <= 8'h00;
            valid     <= 1'b0;
            rev_tick  <= 1'b0;
            rev_cnt   <= '0;
            illegal   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            q_p       <= q;
            first_smp <= 1'b0;
            illegal   <= is_illegal;
            rev_tick  <= 1'b0;
            if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
            case (state)
                ACQ: begin
                    valid    <= 1'b0;
                    phase    <= 3'd0;
                    phase_oh <= 8'h00;
                    if (is_succ) begin
                        if (good_cnt == LOCK_LAST) begin
                            state    <= LOCKED;
                            good_cnt <= 4'd0;
                            valid    <= 1'b1;
                            phase    <= q_dec[2:0];
                            phase_oh <= 8'h01 << q_dec[2:0];
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end else if (!is_stall || stall_bad) begin
                        good_cnt <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state    <= ERROR;
                        valid    <= 1'b0;
                        phase    <= 3'd0;
                        phase_oh <= 8'h00;
                        err      <= 1'b1;
                        err_cnt  <= err_clr ? ERR_W'(1) : err_cnt_inc;
                    end else begin
                        phase    <= q_dec[2:0];
                        phase_oh <= 8'h01 << q_dec[2:0];
                        if (is_succ && q_p == 4'b0001) begin
                            rev_tick <= 1'b1;
                            rev_cnt  <= rev_cnt + REV_W'(1);
                        end
                    end
                end
                ERROR: begin
                    state    <= ACQ;
                    good_cnt <= 4'd0;
                end
                default: state <= ACQ;
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed plus randomized bench for johnson_phase_monitor against a phase-index reference model.
module tb_johnson_phase_monitor;

    localparam int LOCK_N = 4;
    localparam int REV_W  = 8;
    localparam int ERR_W  = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             i = 1'b0;
    logic [3:0]       q = 4'b0000;
    logic             err_clr = 1'b0;
    logic [2:0]       phase;
    logic [7:0]       phase_oh;
    logic             valid, rev_tick, illegal, err;
    logic [REV_W-1:0] rev_cnt;
    logic [ERR_W-1:0] err_cnt;

    johnson_phase_monitor #(.LOCK_N(LOCK_N), .REV_W(REV_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .i(i), .q(q), .err_clr(err_clr),
        .phase(phase), .phase_oh(phase_oh), .valid(valid), .rev_tick(rev_tick),
        .rev_cnt(rev_cnt), .illegal(illegal), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // reference model: positions in the sequence, a run length, and a lock/cooldown flag pair
    logic [3:0] m_prev;
    bit m_first, m_locked, m_cool, m_valid, m_tick, m_ill, m_err;
    int m_run, m_phase, m_rev, m_errs;
    int cidx;

    function automatic int pos(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (codes[k] == c) return k;
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] qv, input logic clr, input logic rb);
        int a, b;
        bit ill, stall, succ, stall_bad, viol;
        if (!rb) begin
            m_prev = 4'b0000; m_first = 1; m_locked = 0; m_cool = 0; m_run = 0;
            m_valid = 0; m_tick = 0; m_ill = 0; m_err = 0; m_phase = 0; m_rev = 0; m_errs = 0;
            return;
        end
        a = pos(qv);
        b = pos(m_prev);
        ill   = (a < 0);
        stall = !ill && (qv == m_prev);
        succ  = !ill && (b >= 0) && (a == (b + 1) % 8);
`ifdef JPM_STALL_EN
        stall_bad = 0;
`else
        stall_bad = stall && !m_first;
`endif
        viol = ill || stall_bad || (!stall && !succ);
        m_ill  = ill;
        m_tick = 0;
        if (clr) begin m_err = 0; m_errs = 0; end
        if (m_cool) begin
            m_cool = 0; m_run = 0;
        end else if (m_locked) begin
            if (viol) begin
                m_locked = 0; m_cool = 1; m_valid = 0; m_phase = 0;
                m_err = 1;
                m_errs = (m_errs + 1 > ERR_MAX) ? ERR_MAX : m_errs + 1;
            end else begin
                m_phase = a;
                if (succ && a == 0) begin
                    m_tick = 1;
                    m_rev = (m_rev + 1) % (1 << REV_W);
                end
            end
        end else begin
            if (succ) m_run++;
            else if (!stall || stall_bad) m_run = 0;
            if (m_run == LOCK_N) begin
                m_locked = 1; m_run = 0; m_valid = 1; m_phase = a;
            end
        end
        m_prev = qv;
        m_first = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] oh;
        oh = m_valid ? (8'h01 << m_phase) : 8'h00;
        chk("phase", 32'(phase), 32'(m_phase));
        chk("phase_oh", 32'(phase_oh), 32'(oh));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("rev_tick", 32'(rev_tick), 32'(m_tick));
        chk("rev_cnt", 32'(rev_cnt), 32'(m_rev));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    endtask

    task automatic tick(input logic [3:0] qv, input logic clr, input logic rb);
        @(negedge clk);
        q = qv; err_clr = clr; i = rb;
        @(posedge clk);
        model_step(qv, clr, rb);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick(codes[cidx], 1'b0, 1'b1);
            cidx = (cidx + 1) % 8;
        end
    endtask

    // advance until the last sampled code was codes[idx]
    task automatic run_to(input int idx);
        for (int k = 0; k < 8; k++) begin
            if ((cidx + 7) % 8 == idx) return;
            run(1);
        end
    endtask

    initial begin
        int r;
        logic [3:0] last;

        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);

        // free-running from 0000: lock on the sample of 1111
        cidx = 0;
        run(4);
        chk("pre_lock_valid", 32'(valid), 32'd0);
        run(1);
        chk("lock_valid", 32'(valid), 32'd1);
        chk("lock_phase", 32'(phase), 32'd4);
        chk("lock_oh", 32'(phase_oh), 32'h10);
        run(4);
        chk("first_rev_tick", 32'(rev_tick), 32'd1);
        chk("first_rev_cnt", 32'(rev_cnt), 32'd1);
        run(8);
        chk("second_rev_cnt", 32'(rev_cnt), 32'd2);

        // one illegal code while locked
        tick(4'b0100, 1'b0, 1'b1);
        cidx = (cidx + 1) % 8;
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_err_cnt", 32'(err_cnt), 32'd1);
        chk("ill_valid", 32'(valid), 32'd0);
        run(4);
        chk("relock_early", 32'(valid), 32'd0);
        run(1);
        chk("relock", 32'(valid), 32'd1);

        // skip 1000 -> 1110
        run(2);
        run_to(1);
        tick(4'b1110, 1'b0, 1'b1);
        cidx = 4;
        chk("skip_err", 32'(err), 32'd1);
        chk("skip_illegal", 32'(illegal), 32'd0);
        chk("skip_err_cnt", 32'(err_cnt), 32'd2);

        // hold 1100 for three samples while locked
        run(6);
        run_to(2);
        tick(4'b1100, 1'b0, 1'b1);
        tick(4'b1100, 1'b0, 1'b1);
        cidx = 3;
        run(8);

        // saturate the error counter
        for (int n = 0; n < 16; n++) begin
            run(6);
            tick(4'b1011, 1'b0, 1'b1);
            cidx = (cidx + 1) % 8;
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'(ERR_MAX));

        // clear alone, then clear coincident with a violation
        tick(codes[cidx], 1'b1, 1'b1);
        cidx = (cidx + 1) % 8;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        run(6);
        tick(4'b0100, 1'b1, 1'b1);
        cidx = (cidx + 1) % 8;
        chk("clr_viol_err", 32'(err), 32'd1);
        chk("clr_viol_err_cnt", 32'(err_cnt), 32'd1);

        // reset mid-lock, then re-lock from 0000
        run(6);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        tick(codes[cidx], 1'b0, 1'b0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rev_cnt", 32'(rev_cnt), 32'd0);
        cidx = 0;
        run(5);
        chk("rst_relock_phase", 32'(phase), 32'd4);
        chk("rst_relock_valid", 32'(valid), 32'd1);

        // randomized traffic
        last = codes[(cidx + 7) % 8];
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                last = codes[cidx]; cidx = (cidx + 1) % 8;
                tick(last, 1'b0, 1'b1);
            end else if (r < 86) begin
                tick(last, 1'b0, 1'b1);
            end else if (r < 91) begin
                last = 4'($urandom_range(0, 15));
                tick(last, 1'b0, 1'b1);
            end else if (r < 96) begin
                cidx = (cidx + $urandom_range(1, 6)) % 8;
                last = codes[cidx]; cidx = (cidx + 1) % 8;
                tick(last, 1'b0, 1'b1);
            end else if (r < 99) begin
                last = codes[cidx]; cidx = (cidx + 1) % 8;
                tick(last, 1'b1, 1'b1);
            end else begin
                tick(last, 1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
